uart_rx_deframer: RTL and testbench

Standalone UART receiver for the serial link between the host and the on-board processor array. It takes the raw asynchronous serial line and recovers 8N1 frames using a fixed clock-per-bit prescaler. Recovered bytes go out on a valid/ready byte stream, with one-cycle status pulses for framing errors and overruns. It is the receiving end of the serial stream that the processor array's transmitter drives at 500 kbaud from a 100 MHz clock.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx_deframer.sv | 139 +++++++++++++
 tb/tb_uart_rx_deframer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides of the
// host <-> processor-array serial link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_DATA_BITS         = 8;
  localparam int UART_DEFAULT_PRESCALER = 200;  // 100 MHz / 500 kbaud

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to
// RESET_VAL so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with a fixed clocks-per-bit prescaler, bit-centre sampling
// and a single-entry valid/ready holding register with overrun detection.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int PRESCALER = UART_DEFAULT_PRESCALER
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
  output logic                      o_overrun
);

  localparam int CW = $clog2(PRESCALER);
  localparam logic [CW-1:0] HALF_LOAD = CW'(PRESCALER / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(PRESCALER - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(UART_DATA_BITS - 1);

  if (PRESCALER < 4) begin : g_bad_prescaler
    $error("uart_rx_deframer: PRESCALER must be >= 4");
  end

  logic                      rx_s;
  logic                      rx_q_reg;
  rx_state_t                 state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [2:0]                idx_reg, idx_next;
  logic [UART_DATA_BITS-1:0] sr_reg, sr_next;
  logic [UART_DATA_BITS-1:0] data_reg, data_next;
  logic                      valid_reg, valid_next;
  logic                      frame_err_reg, frame_err_next;
  logic                      overrun_reg, overrun_next;
  logic                      byte_done;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (uart_rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q_reg      <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      sr_reg        <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_q_reg      <= rx_s;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      sr_reg        <= sr_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    sr_next        = sr_reg;
    byte_done      = 1'b0;
    frame_err_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rx_q_reg && !rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (rx_s) begin
          state_next = IDLE;  // start bit gone by mid-bit: treat as glitch
        end else begin
          state_next = DATA;
          cnt_next   = FULL_LOAD;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          sr_next  = {rx_s, sr_reg[UART_DATA_BITS-1:1]};
          cnt_next = FULL_LOAD;
          if (idx_reg == LAST_IDX) state_next = STOP;
          else                     idx_next   = idx_reg + 3'd1;
        end
      end
      STOP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          // Leave at mid stop bit so a back-to-back start edge is not missed
          state_next     = IDLE;
          byte_done      = rx_s;
          frame_err_next = !rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = 1'b0;
    if (valid_reg && i_ready) valid_next = 1'b0;
    if (byte_done) begin
      if (!valid_reg || i_ready) begin
        data_next  = sr_reg;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench: a fast-prescaler receiver for the directed, table and
// random frames, and a default-prescaler receiver for baud-skew tolerance.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx8, rx200, rdy8, rdy200;
  logic [7:0] data8, data200;
  logic       val8, val200, fe8, fe200, ov8, ov200;

  uart_rx_deframer #(.PRESCALER(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx8), .o_data(data8), .o_valid(val8),
    .i_ready(rdy8), .o_frame_err(fe8), .o_overrun(ov8)
  );

  uart_rx_deframer #(.PRESCALER(200)) dut200 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx200), .o_data(data200), .o_valid(val200),
    .i_ready(rdy200), .o_frame_err(fe200), .o_overrun(ov200)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations taken on the falling edge, away from the active edge
  logic [7:0] acc8[$];
  logic [7:0] acc200[$];
  int         fe_cnt8 = 0, fe_cnt200 = 0, ov_cnt8 = 0, ov_cnt200 = 0;
  int         long_pulse = 0, stab_viol = 0;
  logic       fe8_q = 1'b0, ov8_q = 1'b0, fe200_q = 1'b0, hold8_q = 1'b0;
  logic [7:0] hold_data8 = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      fe8_q   <= 1'b0;
      ov8_q   <= 1'b0;
      fe200_q <= 1'b0;
      hold8_q <= 1'b0;
    end else begin
      if (val8 && rdy8)     acc8.push_back(data8);
      if (val200 && rdy200) acc200.push_back(data200);
      if (fe8)   fe_cnt8   <= fe_cnt8 + 1;
      if (fe200) fe_cnt200 <= fe_cnt200 + 1;
      if (ov8)   ov_cnt8   <= ov_cnt8 + 1;
      if (ov200) ov_cnt200 <= ov_cnt200 + 1;
      if ((fe8 && fe8_q) || (ov8 && ov8_q) || (fe200 && fe200_q))
        long_pulse <= long_pulse + 1;
      if (hold8_q && !(val8 && data8 == hold_data8))
        stab_viol <= stab_viol + 1;
      fe8_q      <= fe8;
      ov8_q      <= ov8;
      fe200_q    <= fe200;
      hold8_q    <= val8 && !rdy8;
      hold_data8 <= data8;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %-24s got %0h expected %0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v, input int cycles);
    if (which == 0) rx8 = v;
    else            rx200 = v;
    tick(cycles);
  endtask

  // One 8N1 frame, LSB first; the line is left idle high afterwards
  task automatic send(input int which, input logic [7:0] b, input logic stop, input int period);
    drive(which, 1'b0, period);
    for (int i = 0; i < 8; i++) drive(which, b[i], period);
    drive(which, stop, period);
    drive(which, 1'b1, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];
  int   b_acc, b_fe, b_ov;
  logic [7:0] exp_q[$];
  int   exp_fe;

  initial begin
    vecs[0] = '{8'h0F, 1'b1, 1, 8'h0F, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{8'h11, 1'b1, 1, 8'h11, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[5] = '{8'h80, 1'b0, 0, 8'h00, 1};
    vecs[6] = '{8'hA5, 1'b1, 1, 8'hA5, 0};

    rst_n = 1'b0; rx8 = 1'b1; rx200 = 1'b1; rdy8 = 1'b1; rdy200 = 1'b1;
    tick(3);
    check("reset_data8", data8, 8'h00);
    check("reset_valid8", val8, 1'b0);
    check("reset_ferr8", fe8, 1'b0);
    check("reset_ovr8", ov8, 1'b0);
    check("reset_data200", data200, 8'h00);
    check("reset_valid200", val200, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // Table-driven single frames
    for (int v = 0; v < 7; v++) begin
      b_acc = acc8.size(); b_fe = fe_cnt8;
      send(0, vecs[v].data, vecs[v].stop, 8);
      tick(16);
      check($sformatf("vec%0d_count", v), acc8.size() - b_acc, vecs[v].exp_valid);
      if (vecs[v].exp_valid != 0 && acc8.size() > b_acc)
        check($sformatf("vec%0d_data", v), acc8[b_acc], vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v), fe_cnt8 - b_fe, vecs[v].exp_ferr);
    end

    // Back-to-back frames
    b_acc = acc8.size(); b_fe = fe_cnt8; b_ov = ov_cnt8;
    send(0, 8'h55, 1'b1, 8);
    send(0, 8'hA3, 1'b1, 8);
    tick(16);
    check("b2b_count", acc8.size() - b_acc, 2);
    if (acc8.size() >= b_acc + 2) begin
      check("b2b_first", acc8[b_acc], 8'h55);
      check("b2b_second", acc8[b_acc+1], 8'hA3);
    end
    check("b2b_errs", (fe_cnt8 - b_fe) + (ov_cnt8 - b_ov), 0);

    // Short low glitch must be rejected, then a clean frame
    b_acc = acc8.size(); b_fe = fe_cnt8;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 16);
    check("glitch_valid", acc8.size() - b_acc, 0);
    check("glitch_ferr", fe_cnt8 - b_fe, 0);
    send(0, 8'h0F, 1'b1, 8);
    tick(16);
    check("post_glitch_count", acc8.size() - b_acc, 1);
    if (acc8.size() > b_acc) check("post_glitch_data", acc8[b_acc], 8'h0F);

    // Overrun with the consumer stalled
    rdy8 = 1'b0;
    b_acc = acc8.size(); b_ov = ov_cnt8;
    send(0, 8'h12, 1'b1, 8);
    send(0, 8'h34, 1'b1, 8);
    tick(16);
    check("ovr_valid_held", val8, 1'b1);
    check("ovr_data_held", data8, 8'h12);
    check("ovr_pulses", ov_cnt8 - b_ov, 1);
    rdy8 = 1'b1;
    tick(10);
    check("ovr_drain_count", acc8.size() - b_acc, 1);
    if (acc8.size() > b_acc) check("ovr_drain_data", acc8[b_acc], 8'h12);
    check("ovr_valid_clear", val8, 1'b0);

    // Reset in the middle of data bit 4 of 0x99
    b_acc = acc8.size(); b_fe = fe_cnt8;
    drive(0, 1'b0, 8);
    drive(0, 1'b1, 8); drive(0, 1'b0, 8); drive(0, 1'b0, 8); drive(0, 1'b1, 8);
    drive(0, 1'b1, 4);
    rst_n = 1'b0;
    tick(1);
    check("midrst_data", data8, 8'h00);
    check("midrst_valid", val8, 1'b0);
    check("midrst_pulses", {fe8, ov8}, 2'b00);
    drive(0, 1'b1, 4);
    drive(0, 1'b0, 8); drive(0, 1'b0, 8); drive(0, 1'b1, 8);
    drive(0, 1'b1, 16);
    rst_n = 1'b1;
    tick(30);
    check("midrst_no_byte", acc8.size() - b_acc, 0);
    check("midrst_no_ferr", fe_cnt8 - b_fe, 0);
    send(0, 8'h66, 1'b1, 8);
    tick(16);
    check("midrst_next_count", acc8.size() - b_acc, 1);
    if (acc8.size() > b_acc) check("midrst_next_data", acc8[b_acc], 8'h66);

    // Default prescaler with +/-2% bit-period skew
    b_acc = acc200.size(); b_fe = fe_cnt200;
    send(1, 8'hFF, 1'b1, 204);
    send(1, 8'h00, 1'b1, 196);
    send(1, 8'h81, 1'b1, 204);
    tick(400);
    check("skew_count", acc200.size() - b_acc, 3);
    if (acc200.size() >= b_acc + 3) begin
      check("skew_ff", acc200[b_acc], 8'hFF);
      check("skew_00", acc200[b_acc+1], 8'h00);
      check("skew_81", acc200[b_acc+2], 8'h81);
    end
    check("skew_ferr", fe_cnt200 - b_fe, 0);

    // Random frames against the frame-level reference model
    b_acc = acc8.size(); b_fe = fe_cnt8; b_ov = ov_cnt8;
    exp_fe = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      if (stop) exp_q.push_back(b);
      else      exp_fe++;
      send(0, b, stop, 8);
      // A bad stop bit must be followed by idle high before the next start edge
      tick(stop ? $urandom_range(0, 12) : 8 + $urandom_range(0, 8));
    end
    tick(40);
    check("rand_count", acc8.size() - b_acc, exp_q.size());
    for (int k = 0; k < exp_q.size() && (b_acc + k) < acc8.size(); k++)
      check($sformatf("rand_byte%0d", k), acc8[b_acc+k], exp_q[k]);
    check("rand_ferr", fe_cnt8 - b_fe, exp_fe);
    check("rand_ovr", ov_cnt8 - b_ov, 0);

    check("pulse_width", long_pulse, 0);
    check("hold_stability", stab_viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
